// File: rtl/exec_sequencer.sv
// Multi-cycle execute-stage sequencer for a sequential Y86-64 core: decodes
// icode/ifun into a shared-ALU request, waits ALU_LAT cycles, commits valE/CC/cnd.
module exec_sequencer #(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] valE,
  output logic             cnd,
  output logic             err,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_COMMIT} state_t;

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  state_t           r_state, w_next;
  logic [2:0]       r_cnt;
  logic [3:0]       r_icode, r_ifun;
  logic [WIDTH-1:0] r_valA, r_valB, r_valC, r_valE, r_alu_a, r_alu_b;
  logic [1:0]       r_alu_op;
  logic             r_cnd, r_err, r_zf, r_sf, r_of;

  logic             w_valid, w_use_alu, w_cond;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a, w_b;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETUP;
      S_SETUP:  w_next = S_WAIT;
      S_WAIT:   if (r_cnt == 3'd0) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Instruction decode from the latched request: legality and ALU operand map.
  always_comb begin
    w_valid   = 1'b0;
    w_use_alu = 1'b0;
    w_op      = 2'b00;
    w_a       = '0;
    w_b       = '0;
    case (r_icode)
      4'h0, 4'h1: w_valid = (r_ifun == 4'd0);
      4'h2: begin
        w_valid = (r_ifun <= 4'd6); w_use_alu = 1'b1; w_a = r_valA;
      end
      4'h3: begin
        w_valid = (r_ifun == 4'd0); w_use_alu = 1'b1; w_a = r_valC;
      end
      4'h4, 4'h5: begin
        w_valid = (r_ifun == 4'd0); w_use_alu = 1'b1; w_a = r_valC; w_b = r_valB;
      end
      4'h6: begin
        w_valid = (r_ifun <= 4'd3); w_use_alu = 1'b1; w_op = r_ifun[1:0];
        w_a = r_valB; w_b = r_valA;
      end
      4'h7: w_valid = (r_ifun <= 4'd6);
      4'h8, 4'hA: begin
        w_valid = (r_ifun == 4'd0); w_use_alu = 1'b1; w_op = 2'b01;
        w_a = r_valB; w_b = WIDTH'(8);
      end
      4'h9, 4'hB: begin
        w_valid = (r_ifun == 4'd0); w_use_alu = 1'b1; w_a = r_valB; w_b = WIDTH'(8);
      end
      default: ;
    endcase
  end

  // Condition evaluated against the CC held before this instruction commits.
  always_comb begin
    w_cond = 1'b0;
    case (r_ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (r_sf ^ r_of) | r_zf;
      4'd2:    w_cond = r_sf ^ r_of;
      4'd3:    w_cond = r_zf;
      4'd4:    w_cond = ~r_zf;
      4'd5:    w_cond = ~(r_sf ^ r_of);
      4'd6:    w_cond = ~(r_sf ^ r_of) & ~r_zf;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_icode  <= '0;
      r_ifun   <= '0;
      r_valA   <= '0;
      r_valB   <= '0;
      r_valC   <= '0;
      r_valE   <= '0;
      r_cnd    <= 1'b0;
      r_err    <= 1'b0;
      r_zf     <= 1'b1;
      r_sf     <= 1'b0;
      r_of     <= 1'b0;
      r_alu_op <= 2'b00;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_icode <= icode;
          r_ifun  <= ifun;
          r_valA  <= valA;
          r_valB  <= valB;
          r_valC  <= valC;
        end
        S_SETUP: begin
          r_alu_op <= w_op;
          r_alu_a  <= w_a;
          r_alu_b  <= w_b;
          r_cnt    <= LAT_M1;
        end
        S_WAIT: begin
          if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
          else begin
            // Results land on entry to COMMIT so they are valid alongside done.
            r_err  <= ~w_valid;
            r_valE <= (w_valid && w_use_alu) ? alu_out : '0;
            r_cnd  <= w_valid && (r_icode == 4'h2 || r_icode == 4'h7) && w_cond;
            if (w_valid && r_icode == 4'h6) begin
              r_zf <= (alu_out == '0);
              r_sf <= alu_out[WIDTH-1];
              r_of <= r_alu_op[1] ? 1'b0 : alu_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_COMMIT);
  assign valE   = r_valE;
  assign cnd    = r_cnd;
  assign err    = r_err;
  assign zf     = r_zf;
  assign sf     = r_sf;
  assign of     = r_of;
  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: two instances (ALU_LAT 1 and 3) driven by
// directed and random instructions; expectations from an instruction-level model.
module tb_exec_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fin_cnt  = 0;

  typedef struct {
    logic [63:0] valE;
    logic        cnd, err, zf, sf, of;
    logic        opchk;
    logic [1:0]  op;
    logic [63:0] a, b;
    int          due;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic cond_of(input logic [3:0] fn, input logic z, s, o);
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (s != o) || z;
      4'd2:    return s != o;
      4'd3:    return z;
      4'd4:    return !z;
      4'd5:    return s == o;
      4'd6:    return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level reference: result, condition, error and the CC after execution.
  function automatic exp_t ref_exec(input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                                    input logic z, s, o);
    exp_t e;
    logic ok;
    logic [63:0] r;
    e.valE = '0; e.cnd = 1'b0; e.err = 1'b0; e.zf = z; e.sf = s; e.of = o;
    e.opchk = 1'b0; e.op = 2'b00; e.a = '0; e.b = '0; e.due = 0;
    case (ic)
      4'h2, 4'h7: ok = (fn <= 4'd6);
      4'h6:       ok = (fn <= 4'd3);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: ok = (fn == 4'd0);
      default:    ok = 1'b0;
    endcase
    if (!ok) begin
      e.err = 1'b1;
      return e;
    end
    case (ic)
      4'h2: begin e.valE = a; e.cnd = cond_of(fn, z, s, o);
                  e.opchk = 1'b1; e.op = 2'b00; e.a = a; e.b = 64'd0; end
      4'h3: begin e.valE = c; e.opchk = 1'b1; e.op = 2'b00; e.a = c; e.b = 64'd0; end
      4'h4, 4'h5: begin e.valE = c + b; e.opchk = 1'b1; e.op = 2'b00; e.a = c; e.b = b; end
      4'h6: begin
        case (fn)
          4'd0: begin r = b + a; e.of = (a[63] == b[63]) && (r[63] != b[63]); end
          4'd1: begin r = b - a; e.of = (a[63] != b[63]) && (r[63] != b[63]); end
          4'd2: begin r = b & a; e.of = 1'b0; end
          default: begin r = b ^ a; e.of = 1'b0; end
        endcase
        e.valE = r; e.zf = (r == 64'd0); e.sf = r[63];
        e.opchk = 1'b1; e.op = fn[1:0]; e.a = b; e.b = a;
      end
      4'h7: e.cnd = cond_of(fn, z, s, o);
      4'h8, 4'hA: begin e.valE = b - 64'd8; e.opchk = 1'b1; e.op = 2'b01; e.a = b; e.b = 64'd8; end
      4'h9, 4'hB: begin e.valE = b + 64'd8; e.opchk = 1'b1; e.op = 2'b00; e.a = b; e.b = 64'd8; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 32));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst, start;
    logic [3:0]  icode, ifun;
    logic [63:0] valA, valB, valC, valE, alu_a, alu_b, alu_out;
    logic        busy, done, cnd, err, zf, sf, of, alu_ovf;
    logic [1:0]  alu_op;
    logic [64:0] sx;

    exec_sequencer #(.WIDTH(64), .ALU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .icode(icode), .ifun(ifun),
      .valA(valA), .valB(valB), .valC(valC), .busy(busy), .done(done),
      .valE(valE), .cnd(cnd), .err(err), .zf(zf), .sf(sf), .of(of),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_ovf(alu_ovf)
    );

    // External ALU; overflow from a sign-extended 65-bit result.
    always_comb begin
      alu_out = '0;
      alu_ovf = 1'b0;
      sx      = '0;
      case (alu_op)
        2'b00: begin sx = {alu_a[63], alu_a} + {alu_b[63], alu_b}; alu_out = sx[63:0]; alu_ovf = sx[64] ^ sx[63]; end
        2'b01: begin sx = {alu_a[63], alu_a} - {alu_b[63], alu_b}; alu_out = sx[63:0]; alu_ovf = sx[64] ^ sx[63]; end
        2'b10: alu_out = alu_a & alu_b;
        default: alu_out = alu_a ^ alu_b;
      endcase
    end

    int   cyc   = 0;
    int   dones = 0;
    exp_t q[$];
    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;

    initial forever begin
      @(posedge clk);
      cyc++;
    end

    initial begin : monitor
      exp_t e;
      forever begin
        @(negedge clk);
        if (done) begin
          dones++;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL L%0d_unexpected_done actual=1 expected=0", LAT);
          end else begin
            e = q.pop_front();
            chk($sformatf("L%0d_valE", LAT), valE, e.valE);
            chk($sformatf("L%0d_cnd", LAT), 64'(cnd), 64'(e.cnd));
            chk($sformatf("L%0d_err", LAT), 64'(err), 64'(e.err));
            chk($sformatf("L%0d_cc", LAT), 64'({zf, sf, of}), 64'({e.zf, e.sf, e.of}));
            chk($sformatf("L%0d_latency", LAT), 64'(cyc), 64'(e.due));
            if (e.opchk) begin
              chk($sformatf("L%0d_alu_op", LAT), 64'(alu_op), 64'(e.op));
              chk($sformatf("L%0d_alu_a", LAT), alu_a, e.a);
              chk($sformatf("L%0d_alu_b", LAT), alu_b, e.b);
            end
          end
        end
      end
    end

    // Holds start until the DUT is seen idle at an edge; optionally leaves start high.
    task automatic issue(input logic [3:0] ic, fn, input logic [63:0] a, b, c, input bit keep);
      bit   acc = 1'b0;
      logic idle;
      int   t = 0;
      exp_t e;
      @(negedge clk);
      icode = ic; ifun = fn; valA = a; valB = b; valC = c; start = 1'b1;
      for (int n = 0; n < 100 && !acc; n++) begin
        if (n > 0) @(negedge clk);
        idle = !busy;
        t    = cyc;
        @(posedge clk);
        acc = idle;
      end
      if (!acc) begin
        checks++;
        failures++;
        $display("FAIL L%0d_accept_timeout actual=busy expected=idle", LAT);
      end else begin
        e     = ref_exec(ic, fn, a, b, c, m_zf, m_sf, m_of);
        e.due = t + 2 + LAT;
        m_zf  = e.zf; m_sf = e.sf; m_of = e.of;
        q.push_back(e);
      end
      #1;
      if (!keep) start = 1'b0;
    endtask

    task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
        @(negedge clk);
        ok = !busy;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL L%0d_idle_timeout actual=busy expected=idle", LAT);
      end
    endtask

    // Reset with start held high: reset must win and every output return to its reset value.
    task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      q.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("L%0d_rst_busy", LAT), 64'(busy), 64'd0);
      chk($sformatf("L%0d_rst_done", LAT), 64'(done), 64'd0);
      chk($sformatf("L%0d_rst_valE", LAT), valE, 64'd0);
      chk($sformatf("L%0d_rst_flags", LAT), 64'({cnd, err, zf, sf, of}), 64'b00100);
      chk($sformatf("L%0d_rst_alu_op", LAT), 64'(alu_op), 64'd0);
      chk($sformatf("L%0d_rst_alu_a", LAT), alu_a, 64'd0);
      chk($sformatf("L%0d_rst_alu_b", LAT), alu_b, 64'd0);
      rst = 1'b0; start = 1'b0;
    endtask

    initial begin : driver
      int          base;
      logic [3:0]  ic, fn;
      rst = 1'b1; start = 1'b0; icode = '0; ifun = '0; valA = '0; valB = '0; valC = '0;
      repeat (2) @(posedge clk);
      do_reset();

      issue(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b0);
      issue(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
      issue(4'h7, 4'h2, 64'd0, 64'd0, 64'h400, 1'b0);
      issue(4'h6, 4'h3, 64'd3, 64'd1, 64'd0, 1'b0);
      issue(4'h2, 4'h4, 64'h1234, 64'd0, 64'd0, 1'b0);

      wait_idle();
      base = dones;
      issue(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1);
      issue(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 1'b0);
      wait_idle();
      repeat (LAT + 4) @(negedge clk);
      chk($sformatf("L%0d_push_pop_dones", LAT), 64'(dones - base), 64'd2);

      issue(4'hD, 4'h0, 64'd7, 64'd7, 64'd7, 1'b0);
      issue(4'h7, 4'h9, 64'd7, 64'd7, 64'd7, 1'b0);

      wait_idle();
      base = dones;
      issue(4'h4, 4'h0, 64'd0, 64'h40, 64'h10, 1'b0);
      repeat ((LAT < 2) ? LAT : 2) @(posedge clk);
      do_reset();
      chk($sformatf("L%0d_no_done_after_rst", LAT), 64'(dones - base), 64'd0);
      issue(4'h4, 4'h0, 64'd0, 64'h40, 64'h10, 1'b0);

      for (int i = 0; i < 60; i++) begin
        ic = 4'($urandom_range(0, 15));
        if (ic >= 4'hC && $urandom_range(0, 3) != 0) ic = ic - 4'h8;
        if ($urandom_range(0, 4) == 0) fn = 4'($urandom_range(0, 15));
        else if (ic == 4'h2 || ic == 4'h7) fn = 4'($urandom_range(0, 6));
        else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
        else fn = 4'h0;
        issue(ic, fn, rand_val(), rand_val(), rand_val(), bit'($urandom_range(0, 1)));
      end
      start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk($sformatf("L%0d_pending", LAT), 64'(q.size()), 64'd0);
      fin_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    wait (fin_cnt == 2);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Multi-cycle controller for the sequential Y86-64 execute stage.
- Accepts one instruction per start pulse and selects ALU operation and operands per icode/ifun.
- Drives a shared external ALU (add/sub/and/xor, 64-bit, with overflow flag), waits ALU_LAT cycles, then commits valE.
- Owns the condition-code register (ZF/SF/OF) and evaluates cnd for cmovXX and jXX. Sits between decode and memory stages.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE/ALU operands.
- ALU_LAT, 1, cycles between ALU operands being stable and alu_out being sampled; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; accepted only in IDLE.
- icode  in  4  instruction code; sampled on accept.
- ifun  in  4  function code; sampled on accept.
- valA  in  WIDTH  operand A; sampled on accept.
- valB  in  WIDTH  operand B; sampled on accept.
- valC  in  WIDTH  constant; sampled on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results are valid.
- valE  out  WIDTH  execute result; held until next commit.
- cnd  out  1  condition result; held until next commit.
- err  out  1  invalid icode/ifun flag; valid with done, held until next commit.
- zf  out  1  CC zero flag.
- sf  out  1  CC sign flag.
- of  out  1  CC overflow flag.
- alu_op  out  2  00 add, 01 sub (a-b), 10 and, 11 xor.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_out  in  WIDTH  ALU result.
- alu_ovf  in  1  ALU signed-overflow flag, for add/sub.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, valE=0, cnd=0, err=0, zf=1, sf=0, of=0, alu_op=00, alu_a=0, alu_b=0, wait counter=0.
- FSM states: IDLE -> SETUP -> WAIT -> COMMIT -> IDLE.
- IDLE:
  - start=1 latches icode/ifun/valA/valB/valC and moves to SETUP.
  - start while busy is ignored; no queueing.
- SETUP: registers alu_op/alu_a/alu_b from the latched instruction, loads counter=ALU_LAT-1, moves to WAIT.
- WAIT: decrements the counter each cycle; moves to COMMIT when the counter is 0. WAIT lasts ALU_LAT cycles.
- COMMIT: samples alu_out into valE, updates CC and cnd, pulses done=1 for exactly one cycle, returns to IDLE.
- Latency: start accepted at edge t -> done high during cycle t+2+ALU_LAT.
- Back-to-back: the next start is accepted the cycle after done (2+ALU_LAT+1 cycle issue interval).
- Operand map (a, b, op):
  - 0x2 cmovXX: valA, 0, add.
  - 0x3 irmovq: valC, 0, add.
  - 0x4 rmmovq / 0x5 mrmovq: valC, valB, add.
  - 0x6 OPq: valB, valA, op=ifun[1:0] (sub yields valB-valA).
  - 0x7 jXX: no ALU use; valE=0.
  - 0x8 call / 0xA pushq: valB, 8, sub.
  - 0x9 ret / 0xB popq: valB, 8, add.
  - 0x0 halt / 0x1 nop: valE=0, cnd=0.
- CC update:
  - Only on COMMIT of a valid OPq.
  - zf = (alu_out==0); sf = alu_out[WIDTH-1].
  - of = alu_ovf for add/sub; of = 0 for and/xor.
  - No other icode touches CC.
- Condition evaluation (cmovXX, jXX) uses the CC value held before this instruction:
  - ifun 0 = 1
  - 1 le = (sf^of)|zf
  - 2 l = sf^of
  - 3 e = zf
  - 4 ne = !zf
  - 5 ge = !(sf^of)
  - 6 g = !(sf^of)&!zf
- cnd=0 for all other icodes.
- Invalid instructions:
  - Invalid cases: icode 0xC-0xF; ifun>6 for icode 2/7; ifun>3 for icode 6; ifun!=0 for other icodes.
  - Sequence still runs the full latency.
  - At COMMIT: err=1, valE=0, cnd=0, CC unchanged.
- Arithmetic wraps modulo 2^WIDTH.
- alu_a/alu_b/alu_op hold their values from SETUP until the next SETUP.
- rst mid-operation: returns to IDLE next edge, no done pulse, all outputs and CC restored to reset values.
- rst and start in the same cycle: rst wins; start is dropped.

Test Plan:
- Reset, then OPq sub (icode 6, ifun 1), valA=5, valB=5, ALU_LAT=1 -> alu_op=01, alu_a=5, alu_b=5; done exactly 3 cycles after accept; valE=0, zf=1, sf=0, of=0, err=0.
- OPq add, valA=1, valB=0x7FFF_FFFF_FFFF_FFFF, then jl (icode 7, ifun 2) -> add: valE=0x8000_0000_0000_0000, sf=1, of=1; jl: cnd=0 (sf^of=0), valE=0.
- OPq xor, valA=3, valB=1 (CC becomes zf=0, sf=0, of=0), then cmovne (icode 2, ifun 4), valA=0x1234 -> valE=0x1234, cnd=1; CC unchanged (zf=0).
- pushq with valB=0x100, then popq with valB=0xF8, with start held high during busy -> valE=0xF8 then 0x100; extra starts while busy are ignored; exactly two done pulses.
- icode 0xD, then icode 7 with ifun 9 -> each gives done with err=1, valE=0, cnd=0; CC unchanged from prior values.
- ALU_LAT=3, rmmovq valB=0x40, valC=0x10, with rst asserted in the second WAIT cycle -> no done pulse; next cycle busy=0, zf=1, valE=0; a fresh rmmovq gives valE=0x50 after 5 cycles.
